// File: rtl/connect4_move_ctrl.sv
// connect4_move_ctrl: owns the 4x4 board, applies gravity to column drops, alternates turns,
// and waits for the detector's verdict before accepting more moves. Undo support: CONNECT4_UNDO_EN.
module connect4_move_ctrl #(
    parameter logic FIRST_PLAYER = 1'b0,
    parameter int   STATUS_WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        drop_req,
    input  logic [1:0]  column,
`ifdef CONNECT4_UNDO_EN
    input  logic        undo_req,
`endif
    input  logic [1:0]  game_status,
    output logic [15:0] game_board,
    output logic [15:0] player_cells,
    output logic        current_player,
    output logic        move_ack,
    output logic        move_reject,
    output logic        busy,
    output logic        game_over,
    output logic [4:0]  move_count
);

    localparam logic [2:0] WAIT_INIT = 3'(STATUS_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_PLACE, S_SETTLE, S_OVER} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_board, r_owner;
    logic        r_player;
    logic        r_move_ack, r_move_reject, r_busy, r_game_over;
    logic [4:0]  r_count;
    logic [1:0]  r_col;
    logic [2:0]  r_wait;
    logic [1:0]  w_row;
    logic [3:0]  w_cell;
    logic        w_start, w_reject, w_ack_go;
`ifdef CONNECT4_UNDO_EN
    logic [3:0]  r_hist_cell;
    logic        r_hist_vld;
    logic        w_undo;
`endif

    // Gravity: lowest empty row of the latched column.
    always_comb begin
        w_row = 2'd3;
        if (!r_board[{2'b10, r_col}]) w_row = 2'd2;
        if (!r_board[{2'b01, r_col}]) w_row = 2'd1;
        if (!r_board[{2'b00, r_col}]) w_row = 2'd0;
    end
    assign w_cell = {w_row, r_col};

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        w_ack_go    = 1'b0;
`ifdef CONNECT4_UNDO_EN
        w_undo      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // The cycle carrying move_ack ignores new requests.
                if (!r_move_ack) begin
`ifdef CONNECT4_UNDO_EN
                    if (undo_req) begin
                        if (r_hist_vld) w_undo = 1'b1;
                        else            w_reject = 1'b1;
                    end else if (drop_req) begin
`else
                    if (drop_req) begin
`endif
                        if (r_board[{2'b11, column}]) begin
                            w_reject = 1'b1;
                        end else begin
                            w_start     = 1'b1;
                            w_state_nxt = S_PLACE;
                        end
                    end
                end
            end
            S_PLACE: w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (r_wait == 3'd1) begin
                    if (game_status == 2'b00) begin
                        w_ack_go    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_OVER;
                    end
                end
            end
            S_OVER: begin
`ifdef CONNECT4_UNDO_EN
                w_reject = drop_req | undo_req;
`else
                w_reject = drop_req;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_board       <= '0;
            r_owner       <= '0;
            r_player      <= FIRST_PLAYER;
            r_move_ack    <= 1'b0;
            r_move_reject <= 1'b0;
            r_busy        <= 1'b0;
            r_game_over   <= 1'b0;
            r_count       <= '0;
            r_col         <= '0;
            r_wait        <= '0;
`ifdef CONNECT4_UNDO_EN
            r_hist_cell   <= '0;
            r_hist_vld    <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_move_reject <= w_reject;
            r_busy        <= (w_state_nxt == S_PLACE) || (w_state_nxt == S_SETTLE);
            r_game_over   <= (w_state_nxt == S_OVER);
`ifdef CONNECT4_UNDO_EN
            r_move_ack    <= w_ack_go | w_undo;
`else
            r_move_ack    <= w_ack_go;
`endif
            if (w_start) r_col <= column;
            if (r_state == S_PLACE) begin
                r_board[w_cell] <= 1'b1;
                r_owner[w_cell] <= r_player;
                r_count         <= r_count + 5'd1;
                r_wait          <= WAIT_INIT;
`ifdef CONNECT4_UNDO_EN
                r_hist_cell     <= w_cell;
                r_hist_vld      <= 1'b1;
`endif
            end
            if (r_state == S_SETTLE) r_wait <= r_wait - 3'd1;
            if (w_ack_go) r_player <= ~r_player;
`ifdef CONNECT4_UNDO_EN
            if (w_undo) begin
                r_board[r_hist_cell] <= 1'b0;
                r_owner[r_hist_cell] <= 1'b0;
                r_count              <= r_count - 5'd1;
                r_player             <= ~r_player;
                r_hist_vld           <= 1'b0;
            end
`endif
        end
    end

    assign game_board     = r_board;
    assign player_cells   = r_owner;
    assign current_player = r_player;
    assign move_ack       = r_move_ack;
    assign move_reject    = r_move_reject;
    assign busy           = r_busy;
    assign game_over      = r_game_over;
    assign move_count     = r_count;

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// Self-checking bench for connect4_move_ctrl: table of whole moves plus hand-written
// timing sequences (latency, busy-ignore, ack-cycle ignore, async reset, undo when built in).
module tb_connect4_move_ctrl;
    localparam int K_ACK  = 0;
    localparam int K_REJ  = 1;
    localparam int K_OVER = 2;
    localparam int NV     = 16;

    logic        clk = 1'b0;
    logic        reset, drop_req;
    logic [1:0]  column, game_status;
`ifdef CONNECT4_UNDO_EN
    logic        undo_req;
`endif
    logic [15:0] game_board, player_cells;
    logic        current_player, move_ack, move_reject, busy, game_over;
    logic [4:0]  move_count;

    int errs = 0;
    int checks = 0;

    connect4_move_ctrl #(.FIRST_PLAYER(1'b0), .STATUS_WAIT(2)) dut (
        .clk(clk), .reset(reset), .drop_req(drop_req), .column(column),
`ifdef CONNECT4_UNDO_EN
        .undo_req(undo_req),
`endif
        .game_status(game_status), .game_board(game_board), .player_cells(player_cells),
        .current_player(current_player), .move_ack(move_ack), .move_reject(move_reject),
        .busy(busy), .game_over(game_over), .move_count(move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [1:0]  col;
        logic [1:0]  st;
        int          kind;
        logic [15:0] board;
        logic [15:0] owner;
        logic        player;
        logic [4:0]  count;
    } vec_t;
    vec_t tv[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_req = 1'b0;
        column = 2'd0;
        game_status = 2'b00;
`ifdef CONNECT4_UNDO_EN
        undo_req = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " board"}, 32'(game_board), 32'h0);
        chk({tag, " owner"}, 32'(player_cells), 32'h0);
        chk({tag, " player"}, 32'(current_player), 32'h0);
        chk({tag, " count"}, 32'(move_count), 32'h0);
        chk({tag, " flags"}, {28'h0, move_ack, move_reject, busy, game_over}, 32'h0);
    endtask

    task automatic pulse_drop(input logic [1:0] c);
        drop_req = 1'b1;
        column = c;
        tick();
        drop_req = 1'b0;
    endtask

    // Drop, then wait (bounded) for ack, reject, or a fresh game_over; one extra cycle
    // afterwards so the next request does not land in the ack cycle.
    task automatic run_move(input logic [1:0] c, output int kind);
        logic was_over;
        was_over = game_over;
        kind = -1;
        pulse_drop(c);
        for (int n = 0; n < 20 && kind < 0; n++) begin
            if (move_ack)                     kind = K_ACK;
            else if (move_reject)             kind = K_REJ;
            else if (game_over && !was_over)  kind = K_OVER;
            else                              tick();
        end
        tick();
        if (move_ack) kind = -2;  // ack must be a single-cycle pulse
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kind;
        int seen_rej;

        //           rst   col   st     kind    board     owner     pl    cnt
        tv[0]  = '{1'b1, 2'd0, 2'b00, K_ACK,  16'h0001, 16'h0000, 1'b1, 5'd1};
        tv[1]  = '{1'b0, 2'd0, 2'b00, K_ACK,  16'h0011, 16'h0010, 1'b0, 5'd2};
        tv[2]  = '{1'b1, 2'd2, 2'b00, K_ACK,  16'h0004, 16'h0000, 1'b1, 5'd1};
        tv[3]  = '{1'b0, 2'd2, 2'b00, K_ACK,  16'h0044, 16'h0040, 1'b0, 5'd2};
        tv[4]  = '{1'b0, 2'd2, 2'b00, K_ACK,  16'h0444, 16'h0040, 1'b1, 5'd3};
        tv[5]  = '{1'b0, 2'd2, 2'b00, K_ACK,  16'h4444, 16'h4040, 1'b0, 5'd4};
        tv[6]  = '{1'b0, 2'd2, 2'b00, K_REJ,  16'h4444, 16'h4040, 1'b0, 5'd4};
        tv[7]  = '{1'b0, 2'd3, 2'b00, K_ACK,  16'h444C, 16'h4040, 1'b1, 5'd5};
        tv[8]  = '{1'b0, 2'd3, 2'b00, K_ACK,  16'h44CC, 16'h40C0, 1'b0, 5'd6};
        tv[9]  = '{1'b0, 2'd1, 2'b01, K_OVER, 16'h44CE, 16'h40C0, 1'b0, 5'd7};
        tv[10] = '{1'b0, 2'd1, 2'b00, K_REJ,  16'h44CE, 16'h40C0, 1'b0, 5'd7};
        tv[11] = '{1'b0, 2'd0, 2'b00, K_REJ,  16'h44CE, 16'h40C0, 1'b0, 5'd7};
        tv[12] = '{1'b1, 2'd1, 2'b11, K_OVER, 16'h0002, 16'h0000, 1'b0, 5'd1};
        tv[13] = '{1'b1, 2'd3, 2'b00, K_ACK,  16'h0008, 16'h0000, 1'b1, 5'd1};
        tv[14] = '{1'b0, 2'd3, 2'b10, K_OVER, 16'h0088, 16'h0080, 1'b1, 5'd2};
        tv[15] = '{1'b0, 2'd0, 2'b00, K_REJ,  16'h0088, 16'h0080, 1'b1, 5'd2};

        do_reset();
        check_reset_vals("reset");

        for (int i = 0; i < NV; i++) begin
            if (tv[i].rst) do_reset();
            game_status = tv[i].st;
            run_move(tv[i].col, kind);
            chk($sformatf("v%0d outcome", i), 32'(kind), 32'(tv[i].kind));
            chk($sformatf("v%0d board", i), 32'(game_board), 32'(tv[i].board));
            chk($sformatf("v%0d owner", i), 32'(player_cells), 32'(tv[i].owner));
            chk($sformatf("v%0d player", i), 32'(current_player), 32'(tv[i].player));
            chk($sformatf("v%0d count", i), 32'(move_count), 32'(tv[i].count));
            chk($sformatf("v%0d game_over", i), 32'(game_over), (tv[i].kind == K_OVER || tv[i].rst == 1'b0 && i >= 10 && i <= 11 || i == 15) ? 32'h1 : 32'h0);
        end

        // Exact latency: board after 2 edges, ack STATUS_WAIT edges later.
        do_reset();
        pulse_drop(2'd0);
        chk("lat E0 busy/board", {15'h0, busy, game_board}, {15'h0, 1'b1, 16'h0000});
        tick();
        chk("lat E1 busy/board", {15'h0, busy, game_board}, {15'h0, 1'b1, 16'h0001});
        tick();
        chk("lat E2 ack/busy", {30'h0, move_ack, busy}, 32'h1);
        tick();
        chk("lat E3 ack/busy/pl", {29'h0, move_ack, busy, current_player}, 32'h5);
        tick();
        chk("lat E4 ack cleared", 32'(move_ack), 32'h0);

        // drop_req during SETTLE and in the ack cycle are both ignored.
        do_reset();
        pulse_drop(2'd0);
        tick();
        pulse_drop(2'd1);
        chk("settle drop no reject", 32'(move_reject), 32'h0);
        seen_rej = 0;
        for (int n = 0; n < 10 && !move_ack; n++) begin
            if (move_reject) seen_rej = 1;
            tick();
        end
        chk("settle ack seen", 32'(move_ack), 32'h1);
        pulse_drop(2'd1);
        chk("ackcyc drop busy/rej", {30'h0, busy, move_reject}, 32'h0);
        tick();
        tick();
        tick();
        chk("ignored drops board", 32'(game_board), 32'h0001);
        chk("ignored drops count", 32'(move_count), 32'h1);
        chk("ignored drops reject", 32'(seen_rej), 32'h0);

        // Asynchronous reset in the middle of SETTLE.
        do_reset();
        pulse_drop(2'd1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_reset_vals("async reset");
        tick();
        reset = 1'b0;
        tick();
        run_move(2'd1, kind);
        chk("post-reset outcome", 32'(kind), 32'(K_ACK));
        chk("post-reset board", 32'(game_board), 32'h0002);
        chk("post-reset count", 32'(move_count), 32'h1);

`ifdef CONNECT4_UNDO_EN
        do_reset();
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        chk("undo empty reject", {30'h0, move_reject, move_ack}, 32'h2);
        tick();
        run_move(2'd3, kind);
        chk("undo pre move", 32'(game_board), 32'h0008);
        undo_req = 1'b1;
        drop_req = 1'b1;
        column = 2'd0;
        tick();
        undo_req = 1'b0;
        drop_req = 1'b0;
        chk("undo ack", {30'h0, move_reject, move_ack}, 32'h1);
        chk("undo board", 32'(game_board), 32'h0000);
        chk("undo count/player", {26'h0, move_count, current_player}, 32'h0);
        chk("undo busy (drop ignored)", 32'(busy), 32'h0);
        tick();
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        chk("second undo reject", {30'h0, move_reject, move_ack}, 32'h2);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
